// File: rtl/div_pkg.sv
// ============================================================================
// div_pkg : shared state encoding and RV32M divide funct3 codes
// Rev 1.0
// ============================================================================
`default_nettype none

package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    // DIV and REM are the signed variants (funct3[0] clear)
    function automatic logic f3_is_signed(input logic [2:0] f3);
        return ~f3[0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/div_seq_ctrl_if.sv
// ============================================================================
// div_seq_ctrl_if : EX-stage <-> sequential divider handshake bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface div_seq_ctrl_if #(
    parameter int WIDTH = 32
) ();

    logic             start;
    logic [2:0]       funct3;
    logic [WIDTH-1:0] rs1_value;
    logic [WIDTH-1:0] rs2_value;
    logic             kill;
    logic             busy;
    logic             stall_pipe;
    logic             done;
    logic [WIDTH-1:0] div_out;

    modport master (
        output start, funct3, rs1_value, rs2_value, kill,
        input  busy, stall_pipe, done, div_out
    );

    modport slave (
        input  start, funct3, rs1_value, rs2_value, kill,
        output busy, stall_pipe, done, div_out
    );

endinterface

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
// div_step : one combinational radix-2 restoring division iteration
// Rev 1.0
// ============================================================================
`default_nettype none

module div_step #(
    parameter int WIDTH = 32
) (
    input  wire logic [WIDTH-1:0] rem,
    input  wire logic [WIDTH-1:0] quo,
    input  wire logic [WIDTH-1:0] divisor,
    output logic      [WIDTH-1:0] rem_n,
    output logic      [WIDTH-1:0] quo_n
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_trial;

    // Extra MSB of the trial difference is its sign: set means "does not fit"
    assign w_shift = {rem, quo[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, divisor};

    assign rem_n = w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
    assign quo_n = {quo[WIDTH-2:0], ~w_trial[WIDTH]};

endmodule

`default_nettype wire

// File: rtl/div_seq_ctrl.sv
// ============================================================================
// div_seq_ctrl : iterative RV32M DIV/DIVU/REM/REMU unit with pipeline stall
// Rev 1.0
// ============================================================================
`default_nettype none

module div_seq_ctrl
    import div_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  wire logic     clk,
    input  wire logic     rst,
    div_seq_ctrl_if.slave bus
);

    localparam logic [WIDTH-1:0] c_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] c_ONES = {WIDTH{1'b1}};
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

    div_state_t       r_state;
    div_state_t       w_state_n;

    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_divisor;
    logic             r_sel_rem;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_div_out;

    logic             w_accept;
    logic             w_signed;
    logic             w_rs1_neg;
    logic             w_rs2_neg;
    logic             w_div_zero;
    logic             w_ovf;
    logic             w_special;
    logic [WIDTH-1:0] w_abs1;
    logic [WIDTH-1:0] w_abs2;
    logic [WIDTH-1:0] w_spec_out;
    logic [WIDTH-1:0] w_rem_n;
    logic [WIDTH-1:0] w_quo_n;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;

    assign w_accept   = (r_state == IDLE) & bus.start & bus.funct3[2] & ~bus.kill;
    assign w_signed   = f3_is_signed(bus.funct3);
    assign w_rs1_neg  = w_signed & bus.rs1_value[WIDTH-1];
    assign w_rs2_neg  = w_signed & bus.rs2_value[WIDTH-1];
    assign w_abs1     = w_rs1_neg ? -bus.rs1_value : bus.rs1_value;
    assign w_abs2     = w_rs2_neg ? -bus.rs2_value : bus.rs2_value;

    assign w_div_zero = (bus.rs2_value == '0);
    assign w_ovf      = w_signed & (bus.rs1_value == c_MIN) & (bus.rs2_value == c_ONES);
    assign w_special  = w_div_zero | w_ovf;
    // Divide-by-zero: q = all ones, r = dividend; overflow: q = MIN, r = 0
    assign w_spec_out = bus.funct3[1] ? (w_div_zero ? bus.rs1_value : '0)
                                      : (w_div_zero ? c_ONES        : c_MIN);

    assign w_quo_fix  = r_neg_q ? -r_quo : r_quo;
    assign w_rem_fix  = r_neg_r ? -r_rem : r_rem;

    div_step #(
        .WIDTH   (WIDTH)
    ) u_step (
        .rem     (r_rem),
        .quo     (r_quo),
        .divisor (r_divisor),
        .rem_n   (w_rem_n),
        .quo_n   (w_quo_n)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        unique case (r_state)
            IDLE: if (w_accept) w_state_n = w_special ? DONE : CALC;
            CALC: if (r_cnt == c_LAST) w_state_n = FIX;
            FIX:  w_state_n = DONE;
            DONE: w_state_n = IDLE;
        endcase
        if (bus.kill && (r_state != IDLE)) begin
            w_state_n = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_sel_rem <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_div_out <= '0;
        end else begin
            if (w_accept) begin
                r_cnt     <= '0;
                r_rem     <= '0;
                r_quo     <= w_abs1;
                r_divisor <= w_abs2;
                r_sel_rem <= bus.funct3[1];
                r_neg_q   <= w_rs1_neg ^ w_rs2_neg;
                r_neg_r   <= w_rs1_neg;
                if (w_special) begin
                    r_div_out <= w_spec_out;
                end
            end
            if ((r_state == CALC) && !bus.kill) begin
                r_rem <= w_rem_n;
                r_quo <= w_quo_n;
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if ((r_state == FIX) && !bus.kill) begin
                r_div_out <= r_sel_rem ? w_rem_fix : w_quo_fix;
            end
        end
    end

    assign bus.busy       = (r_state == CALC) | (r_state == FIX);
    assign bus.stall_pipe = bus.busy | w_accept;
    assign bus.done       = (r_state == DONE) & ~bus.kill;
    assign bus.div_out    = r_div_out;

endmodule

`default_nettype wire
